// File: rtl/config_stream_loader.sv
// config_stream_loader
// Finds a sync word anywhere in the host byte stream, assembles the following
// bytes into configuration words and strobes them out. A frame ends on a
// terminator word or on inactivity, and a one-byte status goes back to the host.
//
// Byte channel (host -> device) and status channel (device -> host) follow
// valid/ready semantics: a transfer happens on a rising clk_i edge where
// valid and ready are both high. The sender holds valid and data steady
// until that edge. Ready is allowed to depend only on state, never on valid.
module config_stream_loader #(
  parameter int unsigned                WORD_WIDTH     = 32,
  parameter logic [WORD_WIDTH-1:0]      SYNC_WORD      = 32'hFAB0_FAB1,
  parameter logic [WORD_WIDTH-1:0]      END_WORD       = 32'hFAB0_FAB0,
  parameter bit                         MSB_FIRST      = 1'b1,
  parameter int unsigned                TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned                COUNT_WIDTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [7:0]             out_data_i,
  input  logic                   out_valid_i,
  output logic                   out_ready_o,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  output logic                   word_write_strobe_o,
  output logic [WORD_WIDTH-1:0]  write_data_o,
  output logic                   active_o,
  output logic [COUNT_WIDTH-1:0] word_count_o,
  output logic [1:0]             dbg_state_o
);

  localparam int unsigned BYTES = WORD_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] STATUS_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] STATUS_TIMEOUT = 8'h54;  // 'T'

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_LOAD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WORD_WIDTH-1:0]  r_window;
  logic [WORD_WIDTH-1:0]  r_asm;
  logic [IDX_W-1:0]       r_idx;
  logic [TMO_W-1:0]       r_tmo;
  logic [7:0]             r_status;
  logic                   r_strobe;
  logic [WORD_WIDTH-1:0]  r_wdata;
  logic [COUNT_WIDTH-1:0] r_count;

  logic                   w_accept;
  logic [WORD_WIDTH-1:0]  w_window_next;
  logic [WORD_WIDTH-1:0]  w_assembled;
  logic                   w_last;
  logic                   w_sync_hit;
  logic                   w_end_hit;
  logic                   w_word_done;
  logic                   w_timeout;

  // Handshake decode, sync window shift and assembly byte placement
  always_comb begin
    w_accept = out_valid_i && (r_state != S_ACK);
    if (MSB_FIRST) w_window_next = {r_window[WORD_WIDTH-9:0], out_data_i};
    else           w_window_next = {out_data_i, r_window[WORD_WIDTH-1:8]};
    w_assembled = r_asm;
    for (int i = 0; i < int'(BYTES); i++) begin
      if (r_idx == IDX_W'(i)) begin
        if (MSB_FIRST) w_assembled[WORD_WIDTH-1-8*i -: 8] = out_data_i;
        else           w_assembled[8*i +: 8]              = out_data_i;
      end
    end
    w_last      = (r_idx == LAST_IDX);
    w_sync_hit  = (r_state == S_HUNT) && w_accept && (w_window_next == SYNC_WORD);
    w_end_hit   = (r_state == S_LOAD) && w_accept && w_last && (w_assembled == END_WORD);
    w_word_done = (r_state == S_LOAD) && w_accept && w_last && (w_assembled != END_WORD);
    // A byte arriving in the same cycle beats the timeout.
    w_timeout   = (r_state == S_LOAD) && !w_accept && (r_tmo == TMO_LAST);
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HUNT:  if (w_sync_hit) w_state_next = S_LOAD;
      S_LOAD:  if (w_end_hit || w_timeout) w_state_next = S_ACK;
      S_ACK:   if (in_ready_i) w_state_next = S_HUNT;
      default: w_state_next = S_HUNT;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_HUNT;
    else            r_state <= w_state_next;
  end

  // Window, assembly, counters, status and word output
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_window <= '0;
      r_asm    <= '0;
      r_idx    <= '0;
      r_tmo    <= '0;
      r_status <= '0;
      r_strobe <= 1'b0;
      r_wdata  <= '0;
      r_count  <= '0;
    end else begin
      r_strobe <= w_word_done;
      case (r_state)
        S_HUNT: begin
          if (w_sync_hit) begin
            r_window <= '0;
            r_asm    <= '0;
            r_idx    <= '0;
            r_tmo    <= '0;
            r_count  <= '0;
          end else if (w_accept) begin
            r_window <= w_window_next;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_tmo <= '0;
            r_asm <= w_assembled;
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_word_done) begin
              r_wdata <= w_assembled;
              if (r_count != '1) r_count <= r_count + COUNT_WIDTH'(1);
            end
            if (w_end_hit) r_status <= STATUS_OK;
          end else if (w_timeout) begin
            // The partial word is dropped; assembly restarts on the next frame.
            r_tmo    <= '0;
            r_idx    <= '0;
            r_status <= STATUS_TIMEOUT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_ACK: begin
          if (in_ready_i) r_window <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_ready_o         = (r_state != S_ACK);
  assign in_valid_o          = (r_state == S_ACK);
  assign in_data_o           = r_status;
  assign active_o            = (r_state == S_LOAD);
  assign word_write_strobe_o = r_strobe;
  assign write_data_o        = r_wdata;
  assign word_count_o        = r_count;
  assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader. Three instances: a 32-bit MSB-first
// loader (m_*), a copy with a 2-bit word counter sharing its stream (s_*), and
// a 16-bit LSB-first loader with its own stream (d_*).
`timescale 1ns/1ps
module tb_config_stream_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]  m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_in_ready = 1'b0;
  logic        m_ready, m_in_valid, m_strobe, m_active;
  logic [7:0]  m_in_data;
  logic [31:0] m_wdata;
  logic [15:0] m_count;
  logic [1:0]  m_state;

  logic        s_ready, s_in_valid, s_strobe, s_active;
  logic [7:0]  s_in_data;
  logic [31:0] s_wdata;
  logic [1:0]  s_count;
  logic [1:0]  s_state;

  logic [7:0]  d_data = '0;
  logic        d_valid = 1'b0;
  logic        d_in_ready = 1'b0;
  logic        d_ready, d_in_valid, d_strobe, d_active;
  logic [7:0]  d_in_data;
  logic [15:0] d_wdata;
  logic [15:0] d_count;
  logic [1:0]  d_state;

  int n_checks = 0;
  int n_fail   = 0;
  int m_strobe_cnt = 0, s_strobe_cnt = 0, d_strobe_cnt = 0;
  int m_status_cnt = 0, d_status_cnt = 0;

  logic [31:0] m_exp_q[$];
  logic [31:0] s_exp_q[$];
  logic [15:0] d_exp_q[$];

  config_stream_loader #(
    .WORD_WIDTH(32), .SYNC_WORD(32'hFAB0_FAB1), .END_WORD(32'hFAB0_FAB0),
    .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(20), .COUNT_WIDTH(16)
  ) u_main (
    .clk_i(clk), .reset_n_i(rst_n), .out_data_i(m_data), .out_valid_i(m_valid),
    .out_ready_o(m_ready), .in_data_o(m_in_data), .in_valid_o(m_in_valid),
    .in_ready_i(m_in_ready), .word_write_strobe_o(m_strobe), .write_data_o(m_wdata),
    .active_o(m_active), .word_count_o(m_count), .dbg_state_o(m_state)
  );

  config_stream_loader #(
    .WORD_WIDTH(32), .SYNC_WORD(32'hFAB0_FAB1), .END_WORD(32'hFAB0_FAB0),
    .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(20), .COUNT_WIDTH(2)
  ) u_sat (
    .clk_i(clk), .reset_n_i(rst_n), .out_data_i(m_data), .out_valid_i(m_valid),
    .out_ready_o(s_ready), .in_data_o(s_in_data), .in_valid_o(s_in_valid),
    .in_ready_i(m_in_ready), .word_write_strobe_o(s_strobe), .write_data_o(s_wdata),
    .active_o(s_active), .word_count_o(s_count), .dbg_state_o(s_state)
  );

  config_stream_loader #(
    .WORD_WIDTH(16), .SYNC_WORD(16'hB1FA), .END_WORD(16'hB0FA),
    .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(20), .COUNT_WIDTH(16)
  ) u_w16 (
    .clk_i(clk), .reset_n_i(rst_n), .out_data_i(d_data), .out_valid_i(d_valid),
    .out_ready_o(d_ready), .in_data_o(d_in_data), .in_valid_o(d_in_valid),
    .in_ready_i(d_in_ready), .word_write_strobe_o(d_strobe), .write_data_o(d_wdata),
    .active_o(d_active), .word_count_o(d_count), .dbg_state_o(d_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: every strobe must match the head of its expected queue
  always @(negedge clk) begin : mon
    logic [31:0] e32;
    logic [15:0] e16;
    if (m_strobe) begin
      m_strobe_cnt++;
      n_checks++;
      if (m_exp_q.size() == 0) begin
        n_fail++; $display("FAIL m_strobe_unexpected got=%h required=none", m_wdata);
      end else begin
        e32 = m_exp_q.pop_front();
        if (m_wdata !== e32) begin
          n_fail++; $display("FAIL m_write_data got=%h required=%h", m_wdata, e32);
        end
      end
    end
    if (s_strobe) begin
      s_strobe_cnt++;
      n_checks++;
      if (s_exp_q.size() == 0) begin
        n_fail++; $display("FAIL s_strobe_unexpected got=%h required=none", s_wdata);
      end else begin
        e32 = s_exp_q.pop_front();
        if (s_wdata !== e32) begin
          n_fail++; $display("FAIL s_write_data got=%h required=%h", s_wdata, e32);
        end
      end
    end
    if (d_strobe) begin
      d_strobe_cnt++;
      n_checks++;
      if (d_exp_q.size() == 0) begin
        n_fail++; $display("FAIL d_strobe_unexpected got=%h required=none", d_wdata);
      end else begin
        e16 = d_exp_q.pop_front();
        if (d_wdata !== e16) begin
          n_fail++; $display("FAIL d_write_data got=%h required=%h", d_wdata, e16);
        end
      end
    end
    if (m_in_valid && m_in_ready) m_status_cnt++;
    if (d_in_valid && d_in_ready) d_status_cnt++;
  end

  // Driver: present one byte and return #1 after the edge that accepted it
  task automatic send_byte(input bit sel16, input logic [7:0] b);
    int guard;
    bit rdy;
    guard = 0;
    if (sel16) begin d_data = b; d_valid = 1'b1; end
    else       begin m_data = b; m_valid = 1'b1; end
    do begin
      @(negedge clk);
      rdy = sel16 ? d_ready : m_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_timeout got=ready_low required=ready_high");
    end
  endtask

  task automatic send_word32(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) send_byte(1'b0, t[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    m_valid = 1'b0;
    d_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++;
    if ({m_ready, m_in_valid, m_strobe, m_active} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_main_flags got=%b required=1000", {m_ready, m_in_valid, m_strobe, m_active});
    end
    n_checks++;
    if (m_in_data !== 8'h00 || m_wdata !== 32'h0 || m_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_main_data got=%h/%h/%h required=00/0/0", m_in_data, m_wdata, m_count);
    end
    n_checks++;
    if (m_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d required=0", m_state);
    end
    n_checks++;
    if ({d_ready, d_in_valid, d_strobe, d_active} !== 4'b1000 || d_count !== 16'h0 || s_count !== 2'd0) begin
      n_fail++; $display("FAIL reset_others got=%b/%h/%h required=1000/0/0", {d_ready, d_in_valid, d_strobe, d_active}, d_count, s_count);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] pre[$];
    int st0, ss0;
    pre = '{8'h00, 8'h11, 8'h22, 8'hFA, 8'hB0, 8'hFA, 8'hB1};
    m_in_ready = 1'b1;
    st0 = m_strobe_cnt; ss0 = m_status_cnt;
    m_exp_q.push_back(32'h1234_5678); m_exp_q.push_back(32'h9ABC_DEF0);
    s_exp_q.push_back(32'h1234_5678); s_exp_q.push_back(32'h9ABC_DEF0);
    n_checks++;
    if (m_active !== 1'b0) begin
      n_fail++; $display("FAIL basic_active_before got=%b required=0", m_active);
    end
    foreach (pre[i]) send_byte(1'b0, pre[i]);
    n_checks++;
    if (m_active !== 1'b1) begin
      n_fail++; $display("FAIL basic_active_after_sync got=%b required=1", m_active);
    end
    send_word32(32'h1234_5678);
    send_word32(32'h9ABC_DEF0);
    send_word32(32'hFAB0_FAB0);
    m_valid = 1'b0;
    n_checks++;
    if ({m_in_valid, m_ready, m_active} !== 3'b100 || m_in_data !== 8'h4B) begin
      n_fail++; $display("FAIL basic_ack got=%b/%h required=100/4b", {m_in_valid, m_ready, m_active}, m_in_data);
    end
    n_checks++;
    if (m_count !== 16'd2 || s_count !== 2'd2) begin
      n_fail++; $display("FAIL basic_count got=%0d/%0d required=2/2", m_count, s_count);
    end
    idle(3);
    n_checks++;
    if (m_strobe_cnt - st0 != 2 || m_status_cnt - ss0 != 1) begin
      n_fail++; $display("FAIL basic_events got=%0d strobes %0d status required=2/1", m_strobe_cnt - st0, m_status_cnt - ss0);
    end
    n_checks++;
    if ({m_in_valid, m_ready, m_active} !== 3'b010) begin
      n_fail++; $display("FAIL basic_back_to_hunt got=%b required=010", {m_in_valid, m_ready, m_active});
    end
  endtask

  task automatic test_width16_lsb();
    logic [7:0] v[$];
    int st0, ss0;
    v = '{8'hFA, 8'hB1, 8'h34, 8'h12, 8'hFA, 8'hB0};
    d_in_ready = 1'b1;
    st0 = d_strobe_cnt; ss0 = d_status_cnt;
    d_exp_q.push_back(16'h1234);
    foreach (v[i]) send_byte(1'b1, v[i]);
    d_valid = 1'b0;
    n_checks++;
    if (d_in_valid !== 1'b1 || d_in_data !== 8'h4B || d_count !== 16'd1) begin
      n_fail++; $display("FAIL w16_ack got=%b/%h/%0d required=1/4b/1", d_in_valid, d_in_data, d_count);
    end
    idle(3);
    n_checks++;
    if (d_strobe_cnt - st0 != 1 || d_status_cnt - ss0 != 1) begin
      n_fail++; $display("FAIL w16_events got=%0d/%0d required=1/1", d_strobe_cnt - st0, d_status_cnt - ss0);
    end
  endtask

  task automatic test_timeout_and_ack_hold();
    int st0, ss0;
    bit bad;
    m_in_ready = 1'b0;
    st0 = m_strobe_cnt; ss0 = m_status_cnt;
    send_word32(32'hFAB0_FAB1);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    idle(19);
    n_checks++;
    if (m_active !== 1'b1 || m_in_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early got=active %b in_valid %b required=1/0", m_active, m_in_valid);
    end
    idle(1);
    n_checks++;
    if ({m_in_valid, m_ready, m_active} !== 3'b100 || m_in_data !== 8'h54) begin
      n_fail++; $display("FAIL timeout_ack got=%b/%h required=100/54", {m_in_valid, m_ready, m_active}, m_in_data);
    end
    n_checks++;
    if (m_count !== 16'd0 || s_count !== 2'd0) begin
      n_fail++; $display("FAIL timeout_count got=%0d/%0d required=0/0", m_count, s_count);
    end
    // Host keeps offering bytes while the status is unread.
    m_data = 8'hFA; m_valid = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_in_valid !== 1'b1 || m_in_data !== 8'h54 || m_ready !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL ack_hold got=%b/%h/%b required=1/54/0", m_in_valid, m_in_data, m_ready);
    end
    m_valid = 1'b0;
    m_in_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({m_in_valid, m_ready, m_active} !== 3'b010) begin
      n_fail++; $display("FAIL ack_release got=%b required=010", {m_in_valid, m_ready, m_active});
    end
    // A fresh frame loads normally after the timeout.
    m_exp_q.push_back(32'h0102_0304); s_exp_q.push_back(32'h0102_0304);
    send_word32(32'hFAB0_FAB1);
    send_word32(32'h0102_0304);
    send_word32(32'hFAB0_FAB0);
    idle(3);
    n_checks++;
    if (m_count !== 16'd1 || m_strobe_cnt - st0 != 1 || m_status_cnt - ss0 != 2) begin
      n_fail++; $display("FAIL reload got=%0d/%0d/%0d required=1/1/2", m_count, m_strobe_cnt - st0, m_status_cnt - ss0);
    end
  endtask

  task automatic test_reset_mid_word();
    int st0, ss0;
    m_in_ready = 1'b1;
    m_exp_q.push_back(32'hAABB_CCDD); s_exp_q.push_back(32'hAABB_CCDD);
    send_word32(32'hFAB0_FAB1);
    send_word32(32'hAABB_CCDD);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    m_valid = 1'b0;
    n_checks++;
    if (m_count !== 16'd1 || m_wdata !== 32'hAABB_CCDD || m_active !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got=%0d/%h/%b required=1/aabbccdd/1", m_count, m_wdata, m_active);
    end
    st0 = m_strobe_cnt; ss0 = m_status_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_ready, m_in_valid, m_strobe, m_active} !== 4'b1000 || m_count !== 16'd0 || m_wdata !== 32'h0 || m_in_data !== 8'h00) begin
      n_fail++; $display("FAIL async_reset got=%b/%0d/%h/%h required=1000/0/0/00", {m_ready, m_in_valid, m_strobe, m_active}, m_count, m_wdata, m_in_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(6);
    n_checks++;
    if (m_strobe_cnt != st0 || m_status_cnt != ss0 || m_active !== 1'b0) begin
      n_fail++; $display("FAIL post_reset got=%0d/%0d/%b required=%0d/%0d/0", m_strobe_cnt, m_status_cnt, m_active, st0, ss0);
    end
  endtask

  task automatic test_saturation();
    int st0, ss0, sst0;
    m_in_ready = 1'b1;
    st0 = m_strobe_cnt; sst0 = s_strobe_cnt; ss0 = m_status_cnt;
    send_word32(32'hFAB0_FAB1);
    for (int i = 1; i <= 5; i++) begin
      m_exp_q.push_back({4{i[7:0]}});
      s_exp_q.push_back({4{i[7:0]}});
      send_word32({4{i[7:0]}});
    end
    send_word32(32'hFAB0_FAB0);
    idle(3);
    n_checks++;
    if (s_count !== 2'd3 || m_count !== 16'd5) begin
      n_fail++; $display("FAIL saturation_count got=%0d/%0d required=3/5", s_count, m_count);
    end
    n_checks++;
    if (s_strobe_cnt - sst0 != 5 || m_strobe_cnt - st0 != 5 || m_status_cnt - ss0 != 1) begin
      n_fail++; $display("FAIL saturation_events got=%0d/%0d/%0d required=5/5/1", s_strobe_cnt - sst0, m_strobe_cnt - st0, m_status_cnt - ss0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_width16_lsb();
    test_timeout_and_ack_hold();
    test_reset_mid_word();
    test_saturation();
    idle(2);
    n_checks++;
    if (m_exp_q.size() != 0 || s_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_strobes got=%0d/%0d/%0d required=0/0/0", m_exp_q.size(), s_exp_q.size(), d_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
